// File: rtl/lsb_queue.sv
// rtl/lsb_queue.sv - in-order load/store queue with operand snooping, single-outstanding memory port and flush drain
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable), flush_in (ROB clear-up)
//   iss_*          : instruction issue from decoder; full refuses it
//   cdb_*          : RS result broadcast, snooped by waiting entries
//   rob_head_*     : oldest uncommitted ROB tag, gates store dispatch
//   mem_*          : one access at a time to the cache, held until mem_done
//   ld_*           : load result broadcast (one-cycle pulse)
//   st_done/st_rob : store completion pulse to the ROB
module lsb_queue #(
    parameter int DEPTH_BITS = 3,
    parameter int ROB_BITS   = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                iss_valid,
    input  logic                iss_is_load,
    input  logic [2:0]          iss_funct3,
    input  logic [31:0]         iss_imm,
    input  logic [31:0]         iss_v1,
    input  logic [31:0]         iss_v2,
    input  logic                iss_dep1,
    input  logic                iss_dep2,
    input  logic [ROB_BITS-1:0] iss_q1,
    input  logic [ROB_BITS-1:0] iss_q2,
    input  logic [ROB_BITS-1:0] iss_rob,
    output logic                full,
    input  logic                cdb_valid,
    input  logic [ROB_BITS-1:0] cdb_rob,
    input  logic [31:0]         cdb_value,
    input  logic                rob_head_valid,
    input  logic [ROB_BITS-1:0] rob_head,
    output logic                mem_req,
    output logic                mem_we,
    output logic [1:0]          mem_size,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_done,
    input  logic [31:0]         mem_rdata,
    output logic                ld_valid,
    output logic [ROB_BITS-1:0] ld_rob,
    output logic [31:0]         ld_value,
    output logic                st_done,
    output logic [ROB_BITS-1:0] st_rob
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic                e_valid  [DEPTH];
    logic                e_load   [DEPTH];
    logic [2:0]          e_funct3 [DEPTH];
    logic [31:0]         e_imm    [DEPTH];
    logic [31:0]         e_v1     [DEPTH];
    logic [31:0]         e_v2     [DEPTH];
    logic                e_dep1   [DEPTH];
    logic                e_dep2   [DEPTH];
    logic [ROB_BITS-1:0] e_q1     [DEPTH];
    logic [ROB_BITS-1:0] e_q2     [DEPTH];
    logic [ROB_BITS-1:0] e_rob    [DEPTH];

    logic [DEPTH_BITS-1:0] head;
    logic [DEPTH_BITS-1:0] tail;
    logic [DEPTH_BITS:0]   count;
    logic [1:0]            state;

    logic push;
    logic pop;
    logic dispatch;
    logic head_ready;
    logic store_ok;

    // count never exceeds DEPTH, so its top bit alone marks a full queue
    assign full = count[DEPTH_BITS];

    // Both broadcast sources: the RS bus and this queue's own load result
    function automatic logic snoop_hit(input logic [ROB_BITS-1:0] q);
        return (cdb_valid && q == cdb_rob) || (ld_valid && q == ld_rob);
    endfunction

    function automatic logic [31:0] snoop_val(input logic [ROB_BITS-1:0] q);
        return (cdb_valid && q == cdb_rob) ? cdb_value : ld_value;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd4:    return {24'd0, raw[7:0]};
            3'd5:    return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_comb begin
        head_ready = e_valid[head] && !e_dep1[head] && !e_dep2[head];
        store_ok   = rob_head_valid && (rob_head == e_rob[head]);
        push       = iss_valid && !full && !flush_in;
        pop        = (state == S_BUSY) && mem_done && !flush_in;
        dispatch   = (state == S_IDLE) && !flush_in && head_ready && (e_load[head] || store_ok);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i]  <= 1'b0;
                e_load[i]   <= 1'b0;
                e_funct3[i] <= '0;
                e_imm[i]    <= '0;
                e_v1[i]     <= '0;
                e_v2[i]     <= '0;
                e_dep1[i]   <= 1'b0;
                e_dep2[i]   <= 1'b0;
                e_q1[i]     <= '0;
                e_q2[i]     <= '0;
                e_rob[i]    <= '0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_valid  <= 1'b0;
            ld_rob    <= '0;
            ld_value  <= '0;
            st_done   <= 1'b0;
            st_rob    <= '0;
        end else if (rdy_in) begin
            ld_valid <= 1'b0;
            st_done  <= 1'b0;
            if (flush_in) begin
                for (int i = 0; i < DEPTH; i++) begin
                    e_valid[i] <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
                // An access completing on the flush cycle is over; otherwise
                // the request must stay up until the cache answers.
                if (state != S_IDLE && mem_done) begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end else if (state == S_BUSY) begin
                    state <= S_DRAIN;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (e_valid[i] && e_dep1[i] && snoop_hit(e_q1[i])) begin
                        e_v1[i]   <= snoop_val(e_q1[i]);
                        e_dep1[i] <= 1'b0;
                    end
                    if (e_valid[i] && e_dep2[i] && snoop_hit(e_q2[i])) begin
                        e_v2[i]   <= snoop_val(e_q2[i]);
                        e_dep2[i] <= 1'b0;
                    end
                end

                if (push) begin
                    e_valid[tail]  <= 1'b1;
                    e_load[tail]   <= iss_is_load;
                    e_funct3[tail] <= iss_funct3;
                    e_imm[tail]    <= iss_imm;
                    e_q1[tail]     <= iss_q1;
                    e_q2[tail]     <= iss_q2;
                    e_rob[tail]    <= iss_rob;
                    // Same-cycle broadcast would otherwise be missed by the new entry
                    if (iss_dep1 && snoop_hit(iss_q1)) begin
                        e_v1[tail]   <= snoop_val(iss_q1);
                        e_dep1[tail] <= 1'b0;
                    end else begin
                        e_v1[tail]   <= iss_v1;
                        e_dep1[tail] <= iss_dep1;
                    end
                    if (iss_dep2 && snoop_hit(iss_q2)) begin
                        e_v2[tail]   <= snoop_val(iss_q2);
                        e_dep2[tail] <= 1'b0;
                    end else begin
                        e_v2[tail]   <= iss_v2;
                        e_dep2[tail] <= iss_dep2;
                    end
                    tail <= tail + DEPTH_BITS'(1);
                end

                if (pop) begin
                    e_valid[head] <= 1'b0;
                    head          <= head + DEPTH_BITS'(1);
                end

                count <= count + {{DEPTH_BITS{1'b0}}, push} - {{DEPTH_BITS{1'b0}}, pop};

                case (state)
                    S_IDLE: begin
                        if (dispatch) begin
                            mem_req   <= 1'b1;
                            mem_we    <= !e_load[head];
                            mem_size  <= e_funct3[head][1:0];
                            mem_addr  <= e_v1[head] + e_imm[head];
                            mem_wdata <= e_v2[head];
                            state     <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (mem_done) begin
                            mem_req <= 1'b0;
                            state   <= S_IDLE;
                            if (e_load[head]) begin
                                ld_valid <= 1'b1;
                                ld_rob   <= e_rob[head];
                                ld_value <= load_extend(e_funct3[head], mem_rdata);
                            end else begin
                                st_done <= 1'b1;
                                st_rob  <= e_rob[head];
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (mem_done) begin
                            mem_req <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/lsb_queue.md
# lsb_queue

Parametrised load/store queue for the out-of-order RISC-V core. It sits between the decoder/issue stage, the ROB, the RS broadcast bus and the memory cache port. It holds memory instructions in program order and resolves their operand dependencies by snooping broadcasts. It sends one access at a time to memory, extends load data per funct3, and survives a ROB flush while a memory access is still in flight.

## Interface
- DEPTH_BITS, 3: queue depth = 2**DEPTH_BITS entries
- ROB_BITS, 4: ROB tag width
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; low freezes all state, outputs hold
- flush_in  in  1  ROB clear-up (mispredict)
- iss_valid  in  1  issue strobe from decoder
- iss_is_load  in  1  1 = load, 0 = store
- iss_funct3  in  3  inst[14:12]
- iss_imm  in  32  sign-extended offset
- iss_v1, iss_v2  in  32  base / store-data operand values
- iss_dep1, iss_dep2  in  1  operand still pending
- iss_q1, iss_q2  in  ROB_BITS  producer tags
- iss_rob  in  ROB_BITS  this instruction's ROB tag
- full  out  1  no free entry; issue ignored
- cdb_valid, cdb_rob, cdb_value  in  1/ROB_BITS/32  RS result broadcast
- rob_head_valid, rob_head  in  1/ROB_BITS  oldest uncommitted ROB tag
- mem_req  out  1  access request, held until mem_done
- mem_we  out  1  1 = store
- mem_size  out  2  funct3[1:0]
- mem_addr, mem_wdata  out  32  v1+imm, v2
- mem_done, mem_rdata  in  1/32  access complete, raw little-endian data in low bits
- ld_valid, ld_rob, ld_value  out  1/ROB_BITS/32  load result broadcast, one-cycle pulse
- st_done, st_rob  out  1/ROB_BITS  store-complete pulse to ROB

## Operation
- Circular buffer: head, tail (DEPTH_BITS, wrap naturally), count (DEPTH_BITS+1). full = (count == 2**DEPTH_BITS).
- Push when iss_valid && !full: entry gets all fields. Pop head on mem_done in state BUSY. Push and pop in the same cycle leave count unchanged.
- Snooping applies every cycle to every valid entry with dep set. The match sources are:
  - cdb_valid && q == cdb_rob → v = cdb_value, dep cleared.
  - Own ld_valid && q == ld_rob → v = ld_value, dep cleared.
  - The same matching applies to the incoming issue fields in the same cycle (bypass), so a broadcast is never lost.
- FSM:
  - IDLE: when the head entry is valid and dep1 == dep2 == 0, it may dispatch. A load dispatches unconditionally. A store dispatches only if rob_head_valid && rob_head == entry rob. On dispatch, drive mem_* from the head entry and go to BUSY.
  - BUSY: hold mem_req and all mem_* outputs stable. On mem_done, pop head; a load emits ld_valid with the extended value, a store emits st_done. Then return to IDLE.
  - DRAIN: entered from BUSY on flush_in. Keep mem_req held. On mem_done, discard the result (no ld_valid/st_done) and go to IDLE.
- Load extension by funct3: 0 = sign-extended byte, 1 = sign-extended half, 2 = word, 4 = zero-extended byte, 5 = zero-extended half. Other encodings return the word unchanged.
- Address = v1 + imm, mod 2**32; no alignment check.
- flush_in (rdy_in high):
  - Clears all entries, head = tail = count = 0.
  - iss_valid in the same cycle is dropped.
  - Snoop and pop results are discarded.
  - FSM transitions: IDLE stays IDLE, BUSY goes to DRAIN, DRAIN stays DRAIN.
- In DRAIN, new issues are accepted, but no dispatch occurs until IDLE.

## Timing
- Reset (async, rst_in low): every output is 0 (full, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ld_valid, ld_rob, ld_value, st_done, st_rob), FSM = IDLE, count = 0.
- Issue into an empty queue with no deps at edge 0 → mem_req high after edge 1.
- mem_done sampled high at edge k → ld_valid/st_done high for exactly the cycle after edge k. The next dispatch can raise mem_req after edge k+1.
- full is derived from the registered count. A push is refused even if a pop happens in the same cycle.
- ld_value is visible to snooping entries at edge k+1 (same edge it is broadcast).
- rdy_in low: nothing changes, mem_done ignored (the cache also stalls).

## Test plan
- Load LW at v1 = 0x1000, imm = 4, no deps, mem_rdata = 0xDEADBEEF → mem_addr = 0x1004, mem_size = 2, ld_value = 0xDEADBEEF, ld_rob = iss_rob.
- LB and LBU with mem_rdata = 0x00000080 → ld_value 0xFFFFFF80 and 0x00000080. LH with 0x0000F00F → 0xFFFFF00F.
- Store tag 3, dep2 on tag 5. Drive cdb (5, 0x55) → v2 = 0x55. Hold rob_head = 2 → no mem_req. Set rob_head = 3 → mem_we = 1, mem_wdata = 0x55, then st_done with st_rob = 3.
- Issue 8 entries with DEPTH_BITS = 3 → full = 1. 9th issue ignored. One pop → full = 0 the following cycle. Push and pop in one cycle keep count.
- Load in BUSY, flush_in pulsed, mem_done two cycles later → no ld_valid, queue empty, mem_req drops. A new issue during DRAIN dispatches only after mem_done.
- Issue with dep1 on tag 7 in the same cycle as cdb (7, 0x2000) → entry captured ready and dispatches next cycle with mem_addr = 0x2000 + imm.
